// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, glitch filter, frame FSM with watchdog, show-ahead FIFO.
// Define PS2_RX_DECODE_EN to fold E0/F0 prefixes into 10-bit tagged scan codes {ext,brk,code}.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          clr_err,
`ifdef PS2_RX_DECODE_EN
  output logic [9:0]                    data,
`else
  output logic [7:0]                    data,
`endif
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err
);

`ifdef PS2_RX_DECODE_EN
  localparam int DW = 10;
`else
  localparam int DW = 8;
`endif
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_s, data_s;
  logic [CNT_W-1:0]       filt_cnt;
  logic                   filt_clk, filt_clk_d, strobe;

  state_t                 state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   par;
  logic [WD_W-1:0]        wd;
  logic                   push_pending;
  logic [DW-1:0]          push_word;
`ifdef PS2_RX_DECODE_EN
  logic                   ext, brk;
`endif

  logic [DW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic                   do_pop, do_push, is_full;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign strobe = filt_clk_d & ~filt_clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync   <= '1;
      data_sync  <= '1;
      filt_cnt   <= '0;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync  <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      filt_clk_d <= filt_clk;
      // The filtered clock only flips after FILTER_LEN consecutive disagreeing samples.
      if (clk_s != filt_clk) begin
        if (filt_cnt == CNT_W'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      par          <= 1'b0;
      wd           <= '0;
      push_pending <= 1'b0;
      push_word    <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
`ifdef PS2_RX_DECODE_EN
      ext          <= 1'b0;
      brk          <= 1'b0;
`endif
    end else begin
      push_pending <= 1'b0;
      // Later event assignments override the clear, so a same-cycle error wins.
      if (clr_err) begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
      if (state != IDLE && !strobe && wd == WD_W'(TIMEOUT_CYC - 1)) begin
        frame_err <= 1'b1;
        state     <= IDLE;
        wd        <= '0;
`ifdef PS2_RX_DECODE_EN
        ext       <= 1'b0;
        brk       <= 1'b0;
`endif
      end else begin
        if (state == IDLE || strobe) wd <= '0;
        else                         wd <= wd + 1'b1;
        if (strobe) begin
          case (state)
            IDLE: begin
              bit_cnt <= '0;
              if (!data_s) state <= DATA;
              else         frame_err <= 1'b1;
            end
            DATA: begin
              shift   <= {data_s, shift[7:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) state <= PARITY;
            end
            PARITY: begin
              par   <= data_s;
              state <= STOP;
            end
            STOP: begin
              state <= IDLE;
              if (data_s && (^{shift, par})) begin
`ifdef PS2_RX_DECODE_EN
                if (shift == 8'hE0) begin
                  ext <= 1'b1;
                end else if (shift == 8'hF0) begin
                  brk <= 1'b1;
                end else begin
                  push_pending <= 1'b1;
                  push_word    <= {ext, brk, shift};
                  ext          <= 1'b0;
                  brk          <= 1'b0;
                end
`else
                push_pending <= 1'b1;
                push_word    <= shift;
`endif
              end else begin
                if (!data_s)          frame_err  <= 1'b1;
                if (!(^{shift, par})) parity_err <= 1'b1;
`ifdef PS2_RX_DECODE_EN
                ext <= 1'b0;
                brk <= 1'b0;
`endif
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign is_full = (level == LW'(FIFO_DEPTH));
  assign do_pop  = rd_en && (level != '0);
  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign do_push = push_pending && (!is_full || do_pop);
  assign valid   = (level != '0);
  assign data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (clr_err) overflow <= 1'b0;
      if (push_pending && is_full && !do_pop) overflow <= 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: table of single frames plus hand-written multi-cycle sequences.
// Honours PS2_RX_DECODE_EN to also exercise prefix decoding.
module tb_ps2_rx_fifo;

`ifdef PS2_RX_DECODE_EN
  localparam int DW = 10;
`else
  localparam int DW = 8;
`endif
  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int HALF  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] data;
  logic          valid;
  logic [3:0]    level;
  logic          overflow, parity_err, frame_err;

  int tests = 0;
  int fails = 0;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .clr_err(clr_err), .data(data), .valid(valid), .level(level), .overflow(overflow),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       bad_stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_level;
    logic       exp_perr;
    logic       exp_ferr;
    logic       do_read;
    logic       do_clr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Device-side bit timing: data changes while the line clock is high.
  task automatic send_bits(input logic [10:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = frame[i];
      cycles(HALF);
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] code, input logic bad_par, input logic bad_stop);
    logic p;
    p = ~(^code) ^ bad_par;
    send_bits({~bad_stop, p, code, 1'b0}, 11);
    cycles(20);
    @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic ev, input int ed, input int el,
                             input logic eo, input logic ep, input logic ef);
    chk({tag, ".valid"}, int'(valid), int'(ev));
    if (ev) chk({tag, ".data"}, int'(data), ed);
    chk({tag, ".level"}, int'(level), el);
    chk({tag, ".overflow"}, int'(overflow), int'(eo));
    chk({tag, ".parity_err"}, int'(parity_err), int'(ep));
    chk({tag, ".frame_err"}, int'(frame_err), int'(ef));
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h2A, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hA3, 1'b0, 1'b0, 1'b1, 8'h55, 2, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hA3, 2, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 2, 1'b0, 1'b0, 1'b1, 1'b0};

    cycles(4);
    @(negedge clk);
    rst = 1'b0;
    cycles(2);
    @(negedge clk);
    checkOutput("reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, int'(vecs[i].exp_data),
                  vecs[i].exp_level, 1'b0, vecs[i].exp_perr, vecs[i].exp_ferr);
      if (vecs[i].do_read) begin
        pop();
        chk($sformatf("vec%0d.level_after_read", i), int'(level), vecs[i].exp_level - 1);
      end
      if (vecs[i].do_clr) begin
        pulse_clr();
        chk($sformatf("vec%0d.perr_after_clr", i), int'(parity_err), 0);
        chk($sformatf("vec%0d.ferr_after_clr", i), int'(frame_err), 0);
      end
    end
    chk("drain.head", int'(data), 8'h00);
    pop();
    chk("drain.valid", int'(valid), 0);

    // Overflow: nine frames into eight slots, the ninth is dropped.
    for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 1'b0, 1'b0);
    checkOutput("full", 1'b1, 8'h01, 8, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("full.read%0d", i), int'(data), i);
      pop();
    end
    chk("full.empty_valid", int'(valid), 0);
    pop();
    chk("full.empty_pop_level", int'(level), 0);
    pulse_clr();
    chk("full.ovf_clr", int'(overflow), 0);

    // Watchdog: start bit plus five data bits, then the line goes quiet.
    send_bits({5'b11111, 6'b010100}, 6);
    cycles(TMO + 50);
    @(negedge clk);
    checkOutput("timeout", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    pulse_clr();
    applyStimulus(8'h2A, 1'b0, 1'b0);
    checkOutput("after_timeout", 1'b1, 8'h2A, 1, 1'b0, 1'b0, 1'b0);
    pop();

    // Short low glitch on the idle clock line must not start a frame.
    @(negedge clk);
    ps2_clk = 1'b0;
    cycles(3);
    ps2_clk = 1'b1;
    cycles(20);
    @(negedge clk);
    checkOutput("glitch", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a frame discards it.
    applyStimulus(8'h77, 1'b0, 1'b0);
    send_bits({5'b11111, 6'b011010}, 4);
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h33, 1'b0, 1'b0);
    checkOutput("after_rst", 1'b1, 8'h33, 1, 1'b0, 1'b0, 1'b0);
    pop();

`ifdef PS2_RX_DECODE_EN
    applyStimulus(8'hE0, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0);
    chk("decode.prefix_level", int'(level), 0);
    applyStimulus(8'h75, 1'b0, 1'b0);
    checkOutput("decode.ext_brk", 1'b1, 10'h375, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    pop();
    checkOutput("decode.plain", 1'b1, 10'h01C, 1, 1'b0, 1'b0, 1'b0);
`else
    applyStimulus(8'hE0, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0);
    checkOutput("raw.e0", 1'b1, 8'hE0, 2, 1'b0, 1'b0, 1'b0);
    pop();
    checkOutput("raw.f0", 1'b1, 8'hF0, 1, 1'b0, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
